// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (F/D, D/E, E/M, M/W) with stall hold, flush bubble, valid, Tnew countdown.
// Latency 1; stall holds every output; flush wins over stall. Optional PIPE_PERF_CNT_EN adds stall/flush counters.
module pipe_stage_reg #(
  parameter int              PC_W          = 32,
  parameter int              DATA_W        = 32,
  parameter int              REG_AW        = 5,
  parameter int              TNEW_W        = 2,
  parameter bit              TNEW_DEC      = 1'b1,
  parameter logic [PC_W-1:0] PC_RST        = PC_W'(32'h3000),
  parameter bit              FLUSH_KEEP_PC = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_regwe,
  input  logic [REG_AW-1:0] in_a3,
  input  logic [DATA_W-1:0] in_regwd,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [REG_AW-1:0] in_rtad,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_regwe,
  output logic [REG_AW-1:0] out_a3,
  output logic [DATA_W-1:0] out_regwd,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [REG_AW-1:0] out_rtad
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic              load_we;
  logic [TNEW_W-1:0] tnew_next;

  // An invalid or non-writing slot carries a3=0 so the hazard unit never matches it.
  always_comb begin
    load_we   = in_regwe & in_valid;
    tnew_next = '0;
    if (in_valid) begin
      if (TNEW_DEC)
        tnew_next = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);
      else
        tnew_next = in_tnew;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pc    <= PC_RST;
      out_regwe <= 1'b0;
      out_a3    <= '0;
      out_regwd <= '0;
      out_tnew  <= '0;
      out_rtad  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_pc    <= FLUSH_KEEP_PC ? in_pc : PC_RST;
      out_regwe <= 1'b0;
      out_a3    <= '0;
      out_regwd <= '0;
      out_tnew  <= '0;
      out_rtad  <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_pc    <= in_pc;
      out_regwe <= load_we;
      out_a3    <= load_we ? in_a3 : '0;
      out_regwd <= in_regwd;
      out_tnew  <= tnew_next;
      out_rtad  <= in_rtad;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Counters saturate rather than wrap so a long run never reads as a small count.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      if (flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end else if (stall) begin
      if (stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: two instances (TNEW_DEC=1/FLUSH_KEEP_PC=1 and TNEW_DEC=0/FLUSH_KEEP_PC=0) share stimulus.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        regwe;
    logic [4:0]  a3;
    logic [31:0] regwd;
    logic [1:0]  tnew;
    logic [4:0]  rtad;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, in_regwe = 1'b0;
  logic [31:0] in_pc = '0, in_regwd = '0;
  logic [4:0]  in_a3 = '0, in_rtad = '0;
  logic [1:0]  in_tnew = '0;

  logic        va, vb, wa, wb;
  logic [31:0] pa, pb, da, db;
  logic [4:0]  aa, ab, ra, rb;
  logic [1:0]  ta, tb;

  obs_t qa[$], qb[$];
  int   checks = 0, passed = 0;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] sc_a, fc_a, sc_b, fc_b;
  logic [63:0] qc[$];
  logic [31:0] exp_sc = '0, exp_fc = '0;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(.TNEW_DEC(1'b1), .FLUSH_KEEP_PC(1'b1)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_regwe(in_regwe), .in_a3(in_a3),
    .in_regwd(in_regwd), .in_tnew(in_tnew), .in_rtad(in_rtad),
    .out_valid(va), .out_pc(pa), .out_regwe(wa), .out_a3(aa),
    .out_regwd(da), .out_tnew(ta), .out_rtad(ra)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(sc_a), .flush_cnt(fc_a)
`endif
  );

  pipe_stage_reg #(.TNEW_DEC(1'b0), .FLUSH_KEEP_PC(1'b0)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_regwe(in_regwe), .in_a3(in_a3),
    .in_regwd(in_regwd), .in_tnew(in_tnew), .in_rtad(in_rtad),
    .out_valid(vb), .out_pc(pb), .out_regwe(wb), .out_a3(ab),
    .out_regwd(db), .out_tnew(tb), .out_rtad(rb)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(sc_b), .flush_cnt(fc_b)
`endif
  );

  function automatic obs_t mk(input logic v, input logic [31:0] p, input logic we,
                              input logic [4:0] a, input logic [31:0] d,
                              input logic [1:0] t, input logic [4:0] r);
    obs_t o;
    o = '{valid: v, pc: p, regwe: we, a3: a, regwd: d, tnew: t, rtad: r};
    return o;
  endfunction

  // Inputs change on the falling edge; the expected registered result is queued for the next rising edge.
  task automatic step(input logic st, input logic fl, input logic rs, input obs_t in,
                      input obs_t ea, input logic [1:0] b_tnew, input logic [31:0] b_pc);
    obs_t eb;
    @(negedge clk);
    stall = st; flush = fl; reset = rs;
    in_valid = in.valid; in_pc = in.pc; in_regwe = in.regwe; in_a3 = in.a3;
    in_regwd = in.regwd; in_tnew = in.tnew; in_rtad = in.rtad;
    eb = ea; eb.tnew = b_tnew; eb.pc = b_pc;
    qa.push_back(ea);
    qb.push_back(eb);
`ifdef PIPE_PERF_CNT_EN
    if (rs) begin
      exp_sc = '0; exp_fc = '0;
    end else if (fl) begin
      if (exp_fc != 32'hFFFF_FFFF) exp_fc = exp_fc + 1;
    end else if (st) begin
      if (exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 1;
    end
    qc.push_back({exp_sc, exp_fc});
`endif
  endtask

  // Monitor: registered outputs are presented every cycle that has a queued expectation.
  initial begin
    obs_t got, exp;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() != 0) begin
        exp = qa.pop_front();
        got = {va, pa, wa, aa, da, ta, ra};
        checks++;
        if (got !== exp) $display("FAIL dut_a_outputs got=%h want=%h t=%0t", got, exp, $time);
        else passed++;
      end
      if (qb.size() != 0) begin
        exp = qb.pop_front();
        got = {vb, pb, wb, ab, db, tb, rb};
        checks++;
        if (got !== exp) $display("FAIL dut_b_outputs got=%h want=%h t=%0t", got, exp, $time);
        else passed++;
      end
`ifdef PIPE_PERF_CNT_EN
      if (qc.size() != 0) begin
        logic [63:0] ec;
        ec = qc.pop_front();
        checks++;
        if ({sc_a, fc_a} !== ec || {sc_b, fc_b} !== ec)
          $display("FAIL perf_counters got=%h/%h want=%h t=%0t", {sc_a, fc_a}, {sc_b, fc_b}, ec, $time);
        else passed++;
      end
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t r0, l4, junk;
    r0   = mk(1'b0, 32'h3000, 1'b0, 5'd0, 32'h0, 2'd0, 5'd0);
    junk = mk(1'b1, 32'h1234, 1'b1, 5'd17, 32'h5A5A_5A5A, 2'd3, 5'd12);

    // Reset held two cycles: garbage on the inputs must not leak through.
    step(0, 0, 1, junk, r0, 2'd0, 32'h3000);
    step(1, 1, 1, junk, r0, 2'd0, 32'h3000);

    // Loads: Tnew countdown on dut_a (2->1, 0->0, 3->2), pass-through on dut_b.
    step(0, 0, 0, mk(1, 32'h3004, 1, 5'd8, 32'hDEAD_BEEF, 2'd2, 5'd3),
         mk(1, 32'h3004, 1, 5'd8, 32'hDEAD_BEEF, 2'd1, 5'd3), 2'd2, 32'h3004);
    step(0, 0, 0, mk(1, 32'h3008, 1, 5'd8, 32'hCAFE_F00D, 2'd0, 5'd4),
         mk(1, 32'h3008, 1, 5'd8, 32'hCAFE_F00D, 2'd0, 5'd4), 2'd0, 32'h3008);
    step(0, 0, 0, mk(1, 32'hFFFF_FFFC, 1, 5'd31, 32'h1234_5678, 2'd3, 5'd31),
         mk(1, 32'hFFFF_FFFC, 1, 5'd31, 32'h1234_5678, 2'd2, 5'd31), 2'd3, 32'hFFFF_FFFC);
    l4 = mk(1, 32'h3004, 1, 5'd8, 32'hDEAD_BEEF, 2'd1, 5'd3);
    step(0, 0, 0, mk(1, 32'h3004, 1, 5'd8, 32'hDEAD_BEEF, 2'd2, 5'd3), l4, 2'd2, 32'h3004);

    // Stall three cycles while the inputs move on: everything holds, Tnew included.
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, mk(1, 32'h3008, 1, 5'd10 + 5'(i), 32'h0BAD_0000 + i, 2'd3, 5'd7), l4, 2'd2, 32'h3004);

    // Flush beats stall; dut_a keeps in_pc, dut_b reloads PC_RST.
    step(1, 1, 0, mk(1, 32'h300C, 1, 5'd7, 32'h7777_7777, 2'd3, 5'd5),
         mk(0, 32'h300C, 0, 5'd0, 32'h0, 2'd0, 5'd0), 2'd0, 32'h3000);
    step(0, 1, 0, mk(1, 32'h3010, 1, 5'd6, 32'h6666_6666, 2'd2, 5'd6),
         mk(0, 32'h3010, 0, 5'd0, 32'h0, 2'd0, 5'd0), 2'd0, 32'h3000);

    // Write-enable gating: invalid slot, non-writing slot, and $0 destination passed through.
    step(0, 0, 0, mk(0, 32'h3014, 1, 5'd9, 32'h0000_0055, 2'd2, 5'd6),
         mk(0, 32'h3014, 0, 5'd0, 32'h0000_0055, 2'd0, 5'd6), 2'd0, 32'h3014);
    step(0, 0, 0, mk(1, 32'h3018, 0, 5'd9, 32'h0000_00AA, 2'd1, 5'd2),
         mk(1, 32'h3018, 0, 5'd0, 32'h0000_00AA, 2'd0, 5'd2), 2'd1, 32'h3018);
    l4 = mk(1, 32'h301C, 1, 5'd0, 32'h0000_0001, 2'd0, 5'd1);
    step(0, 0, 0, mk(1, 32'h301C, 1, 5'd0, 32'h0000_0001, 2'd1, 5'd1), l4, 2'd1, 32'h301C);

`ifdef PIPE_PERF_CNT_EN
    // Preload the stall counters just below saturation, then keep stalling.
    exp_sc = 32'hFFFF_FFFC;
    step(1, 0, 0, junk, l4, 2'd1, 32'h301C);
    force dut_a.stall_cnt = 32'hFFFF_FFFC;
    force dut_b.stall_cnt = 32'hFFFF_FFFC;
    #1;
    release dut_a.stall_cnt;
    release dut_b.stall_cnt;
    for (int i = 0; i < 3; i++) step(1, 0, 0, junk, l4, 2'd1, 32'h301C);
`else
    for (int i = 0; i < 2; i++) step(1, 0, 0, junk, l4, 2'd1, 32'h301C);
`endif

    // Reset in the middle of a stall, then recover with a fresh load.
    step(1, 0, 1, junk, r0, 2'd0, 32'h3000);
    step(0, 0, 0, mk(1, 32'h3020, 1, 5'd2, 32'h0000_2020, 2'd1, 5'd3),
         mk(1, 32'h3020, 1, 5'd2, 32'h0000_2020, 2'd0, 5'd3), 2'd1, 32'h3020);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (qa.size() != 0 || qb.size() != 0)
      $display("FAIL scoreboard_drain left=%0d/%0d want=0", qa.size(), qb.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
